// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, queues fetched words in a
// 2-entry FIFO for decode, and handles redirects, back-pressure and fetch faults.
module imem_fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 168
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] inst_addr,
  input  logic [31:0] inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        deq_ready,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        fault
);

  // One extra bit so an overflowing pc + 4 compares as out of range.
  localparam logic [64:0] ImemLimit = 65'(IMEM_BYTES);

  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [63:0] pc_mem_q [2];
  logic [63:0] pc_mem_d [2];
  logic [31:0] inst_mem_q [2];
  logic [31:0] inst_mem_d [2];

  logic [64:0] pc_plus4_wide;
  logic        pc_legal;
  logic        fetch_ok;
  logic        pop;
  logic        push;

  // Fetch legality and queue handshake decode.
  always_comb begin
    pc_plus4_wide = {1'b0, fetch_pc_q} + 65'd4;
    pc_legal      = (fetch_pc_q[1:0] == 2'b00) && (pc_plus4_wide <= ImemLimit);
    fetch_ok      = !fault_q && pc_legal;
    pop           = out_valid && deq_ready;
    push          = fetch_ok && !redirect_valid && ((count_q != 2'd2) || pop);
  end

  // Next-state: redirect flushes everything and wins over push, pop and fault set.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      fault_d    = 1'b0;
      count_d    = 2'd0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[tail_q]   = fetch_pc_q;
        inst_mem_d[tail_q] = inst;
        tail_d             = ~tail_q;
        fetch_pc_d         = fetch_pc_q + 64'd4;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (!fault_q && !pc_legal) begin
        fault_d = 1'b1;
      end
    end
  end

  // State registers; FIFO storage is cleared on reset as well.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pc_mem_q[i]   <= 64'd0;
        inst_mem_q[i] <= 32'd0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  // Outputs come straight from state.
  always_comb begin
    inst_addr = fetch_pc_q;
    out_valid = (count_q != 2'd0);
    out_pc    = pc_mem_q[head_q];
    out_inst  = inst_mem_q[head_q];
    fault     = fault_q;
  end

endmodule
